// File: rtl/ethernet_irq_coalesce_unit.sv
// Multi-channel interrupt coalescing unit for the Ethernet controller.
// Each channel counts completion events. It raises pending when the event count
// reaches a threshold, or when a timeout expires after the first event.
module ethernet_irq_coalesce_unit #(
  parameter int unsigned num_chan_p    = 4,
  parameter int unsigned count_width_p = 8,
  parameter int unsigned timer_width_p = 16,
  localparam int unsigned chan_width_lp = (num_chan_p > 1) ? $clog2(num_chan_p) : 1
) (
  input  logic                              clk_i,
  input  logic                              reset_n_i,
  input  logic [num_chan_p-1:0]             event_v_i,
  input  logic                              cfg_v_i,
  input  logic [chan_width_lp-1:0]          cfg_chan_i,
  input  logic                              cfg_enable_i,
  input  logic [count_width_p-1:0]          cfg_thresh_i,
  input  logic [timer_width_p-1:0]          cfg_timeout_i,
  input  logic [num_chan_p-1:0]             clear_v_i,
  output logic [num_chan_p-1:0]             pending_o,
  output logic [num_chan_p*count_width_p-1:0] count_o,
  output logic                              irq_o
);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_PENDING = 2'd2
  } chan_state_e;

  localparam logic [count_width_p-1:0] count_one_lp = count_width_p'(1);
  localparam logic [timer_width_p-1:0] timer_one_lp = timer_width_p'(1);

  // Per-channel configuration
  logic                     enable_q  [num_chan_p];
  logic [count_width_p-1:0] thresh_q  [num_chan_p];
  logic [timer_width_p-1:0] timeout_q [num_chan_p];

  // Per-channel coalescing state
  chan_state_e              state_q   [num_chan_p];
  chan_state_e              state_n   [num_chan_p];
  logic [count_width_p-1:0] count_q   [num_chan_p];
  logic [count_width_p-1:0] count_n   [num_chan_p];
  logic [timer_width_p-1:0] timer_q   [num_chan_p];
  logic [timer_width_p-1:0] timer_n   [num_chan_p];
  logic [num_chan_p-1:0]    pending_q;

  // Helper values derived from the registered state
  logic [count_width_p-1:0] eff_thresh [num_chan_p];
  logic [count_width_p-1:0] count_inc  [num_chan_p];
  logic [timer_width_p-1:0] timer_inc  [num_chan_p];

  // Configuration registers: a write lands at the edge and is used from the next cycle
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < num_chan_p; i++) begin
        enable_q[i]  <= 1'b0;
        thresh_q[i]  <= count_one_lp;
        timeout_q[i] <= '0;
      end
    end else if (cfg_v_i) begin
      for (int unsigned i = 0; i < num_chan_p; i++) begin
        if (cfg_chan_i == chan_width_lp'(i)) begin
          enable_q[i]  <= cfg_enable_i;
          thresh_q[i]  <= cfg_thresh_i;
          timeout_q[i] <= cfg_timeout_i;
        end
      end
    end
  end

  // Effective threshold (0 acts as 1) and saturating increments
  always_comb begin
    for (int unsigned i = 0; i < num_chan_p; i++) begin
      eff_thresh[i] = (thresh_q[i] == '0) ? count_one_lp : thresh_q[i];
      count_inc[i]  = (count_q[i] == '1) ? count_q[i] : count_q[i] + count_one_lp;
      timer_inc[i]  = (timer_q[i] == '1) ? timer_q[i] : timer_q[i] + timer_one_lp;
    end
  end

  // Next-state logic for each channel FSM
  always_comb begin
    for (int unsigned i = 0; i < num_chan_p; i++) begin
      state_n[i] = state_q[i];
      count_n[i] = count_q[i];
      timer_n[i] = timer_q[i];

      if (!enable_q[i]) begin
        state_n[i] = ST_IDLE;
        count_n[i] = '0;
        timer_n[i] = '0;
      end else begin
        case (state_q[i])
          ST_IDLE: begin
            count_n[i] = '0;
            timer_n[i] = '0;
            if (event_v_i[i]) begin
              count_n[i] = count_one_lp;
              state_n[i] = (eff_thresh[i] == count_one_lp) ? ST_PENDING : ST_ARMED;
            end
          end
          ST_ARMED: begin
            timer_n[i] = timer_inc[i];
            if (event_v_i[i]) begin
              count_n[i] = count_inc[i];
            end
            // Threshold and timeout both use this cycle's updated values
            if ((count_n[i] >= eff_thresh[i]) ||
                ((timeout_q[i] != '0) && (timer_n[i] >= timeout_q[i]))) begin
              state_n[i] = ST_PENDING;
            end
          end
          ST_PENDING: begin
            if (event_v_i[i]) begin
              count_n[i] = count_inc[i];
            end
            if (clear_v_i[i]) begin
              timer_n[i] = '0;
              if (event_v_i[i]) begin
                state_n[i] = ST_ARMED;
                count_n[i] = count_one_lp;
              end else begin
                state_n[i] = ST_IDLE;
                count_n[i] = '0;
              end
            end
          end
          default: begin
            state_n[i] = ST_IDLE;
            count_n[i] = '0;
            timer_n[i] = '0;
          end
        endcase
      end
    end
  end

  // Channel state registers, including a registered copy of pending
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      for (int unsigned i = 0; i < num_chan_p; i++) begin
        state_q[i] <= ST_IDLE;
        count_q[i] <= '0;
        timer_q[i] <= '0;
      end
      pending_q <= '0;
    end else begin
      for (int unsigned i = 0; i < num_chan_p; i++) begin
        state_q[i]   <= state_n[i];
        count_q[i]   <= count_n[i];
        timer_q[i]   <= timer_n[i];
        pending_q[i] <= (state_n[i] == ST_PENDING);
      end
    end
  end

  // Output packing and interrupt line
  always_comb begin
    count_o = '0;
    for (int unsigned i = 0; i < num_chan_p; i++) begin
      count_o[i*count_width_p +: count_width_p] = count_q[i];
    end
    pending_o = pending_q;
    irq_o     = |pending_q;
  end

endmodule

// File: tb/tb_ethernet_irq_coalesce_unit.sv
// Directed self-checking bench for ethernet_irq_coalesce_unit.
module tb_ethernet_irq_coalesce_unit;

  localparam int unsigned NC = 4;
  localparam int unsigned CW = 8;
  localparam int unsigned TW = 16;

  logic              clk_i = 1'b0;
  logic              reset_n_i;
  logic [NC-1:0]     event_v_i;
  logic              cfg_v_i;
  logic [1:0]        cfg_chan_i;
  logic              cfg_enable_i;
  logic [CW-1:0]     cfg_thresh_i;
  logic [TW-1:0]     cfg_timeout_i;
  logic [NC-1:0]     clear_v_i;
  logic [NC-1:0]     pending_o;
  logic [NC*CW-1:0]  count_o;
  logic              irq_o;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  always #5 clk_i = ~clk_i;

  ethernet_irq_coalesce_unit #(
    .num_chan_p   (NC),
    .count_width_p(CW),
    .timer_width_p(TW)
  ) dut (
    .clk_i        (clk_i),
    .reset_n_i    (reset_n_i),
    .event_v_i    (event_v_i),
    .cfg_v_i      (cfg_v_i),
    .cfg_chan_i   (cfg_chan_i),
    .cfg_enable_i (cfg_enable_i),
    .cfg_thresh_i (cfg_thresh_i),
    .cfg_timeout_i(cfg_timeout_i),
    .clear_v_i    (clear_v_i),
    .pending_o    (pending_o),
    .count_o      (count_o),
    .irq_o        (irq_o)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] cnt(input int unsigned ch);
    return 32'(count_o[ch*CW +: CW]);
  endfunction

  // Advance n clock edges; return 1 time unit after the last edge
  task automatic tick(input int unsigned n);
    for (int unsigned k = 0; k < n; k++) begin
      @(posedge clk_i);
      #1;
    end
  endtask

  task automatic cfg_write(input int unsigned ch, input logic en,
                           input logic [CW-1:0] th, input logic [TW-1:0] to);
    cfg_v_i       = 1'b1;
    cfg_chan_i    = 2'(ch);
    cfg_enable_i  = en;
    cfg_thresh_i  = th;
    cfg_timeout_i = to;
    tick(1);
    cfg_v_i = 1'b0;
  endtask

  task automatic ev(input logic [NC-1:0] mask);
    event_v_i = mask;
    tick(1);
    event_v_i = '0;
  endtask

  task automatic clr(input logic [NC-1:0] cmask, input logic [NC-1:0] emask);
    clear_v_i = cmask;
    event_v_i = emask;
    tick(1);
    clear_v_i = '0;
    event_v_i = '0;
  endtask

  initial begin
    reset_n_i     = 1'b0;
    event_v_i     = '0;
    cfg_v_i       = 1'b0;
    cfg_chan_i    = '0;
    cfg_enable_i  = 1'b0;
    cfg_thresh_i  = '0;
    cfg_timeout_i = '0;
    clear_v_i     = '0;

    // Reset values, then events on disabled channels
    tick(2);
    check_eq("rst_pending", 32'(pending_o), 32'h0);
    check_eq("rst_count", count_o, 32'h0);
    check_eq("rst_irq", 32'(irq_o), 32'h0);
    reset_n_i = 1'b1;
    tick(1);
    ev(4'hF);
    ev(4'hF);
    check_eq("dis_count", count_o, 32'h0);
    check_eq("dis_pending", 32'(pending_o), 32'h0);

    // Channel 0: threshold 4, events every 3 cycles
    cfg_write(0, 1'b1, 8'd4, 16'd0);
    for (int unsigned k = 0; k < 4; k++) begin
      ev(4'b0001);
      if (k < 3) begin
        tick(2);
      end
    end
    check_eq("th4_pending", 32'(pending_o), 32'h1);
    check_eq("th4_count", cnt(0), 32'd4);
    check_eq("th4_irq", 32'(irq_o), 32'h1);
    clr(4'b0001, 4'b0000);
    check_eq("th4_clr_pending", 32'(pending_o), 32'h0);
    check_eq("th4_clr_count", cnt(0), 32'd0);
    check_eq("th4_clr_irq", 32'(irq_o), 32'h0);

    // Threshold 0 behaves as 1: pending the cycle after the event
    cfg_write(0, 1'b1, 8'd0, 16'd0);
    ev(4'b0001);
    check_eq("th0_pending", 32'(pending_o), 32'h1);
    check_eq("th0_count", cnt(0), 32'd1);
    clr(4'b0001, 4'b0000);

    // Channel 1: threshold 8, timeout 20; a second event does not move the deadline
    cfg_write(1, 1'b1, 8'd8, 16'd20);
    ev(4'b0010);
    check_eq("to_first_count", cnt(1), 32'd1);
    check_eq("to_first_pending", 32'(pending_o), 32'h0);
    tick(4);
    ev(4'b0010);
    check_eq("to_second_count", cnt(1), 32'd2);
    tick(14);
    check_eq("to_t19_pending", 32'(pending_o), 32'h0);
    tick(1);
    check_eq("to_t20_pending", 32'(pending_o), 32'h2);
    check_eq("to_t20_irq", 32'(irq_o), 32'h1);
    clr(4'b0010, 4'b0000);
    check_eq("to_clr_pending", 32'(pending_o), 32'h0);

    // Channel 2: clear with a simultaneous event re-arms with count 1
    cfg_write(2, 1'b1, 8'd3, 16'd0);
    ev(4'b0100);
    ev(4'b0100);
    ev(4'b0100);
    check_eq("c2_pend", 32'(pending_o), 32'h4);
    check_eq("c2_pend_count", cnt(2), 32'd3);
    clr(4'b0100, 4'b0100);
    check_eq("c2_rearm_pending", 32'(pending_o), 32'h0);
    check_eq("c2_rearm_count", cnt(2), 32'd1);
    tick(1);
    check_eq("c2_armed_pending", 32'(pending_o), 32'h0);
    clr(4'b0100, 4'b0000);
    check_eq("c2_armed_clr_count", cnt(2), 32'd1);
    ev(4'b0100);
    check_eq("c2_armed_count2", cnt(2), 32'd2);
    // Lowering the threshold to the current count takes effect one cycle later
    cfg_write(2, 1'b1, 8'd2, 16'd0);
    check_eq("c2_lower_same", 32'(pending_o), 32'h0);
    tick(1);
    check_eq("c2_lower_next", 32'(pending_o), 32'h4);
    clr(4'b0100, 4'b0000);

    // Channel 3: saturation at 255 with threshold 255
    cfg_write(3, 1'b1, 8'd255, 16'd0);
    event_v_i = 4'b1000;
    tick(254);
    check_eq("sat_254_count", cnt(3), 32'd254);
    check_eq("sat_254_pending", 32'(pending_o), 32'h0);
    tick(1);
    check_eq("sat_255_count", cnt(3), 32'd255);
    check_eq("sat_255_pending", 32'(pending_o), 32'h8);
    tick(45);
    event_v_i = '0;
    check_eq("sat_300_count", cnt(3), 32'd255);
    check_eq("sat_300_pending", 32'(pending_o), 32'h8);
    cfg_write(3, 1'b0, 8'd255, 16'd0);
    tick(1);
    check_eq("dis3_count", cnt(3), 32'd0);
    check_eq("dis3_pending", 32'(pending_o), 32'h0);

    // Reset in the middle of ARMED on every channel
    for (int unsigned ch = 0; ch < NC; ch++) begin
      cfg_write(ch, 1'b1, 8'd100, 16'd0);
    end
    ev(4'hF);
    ev(4'hF);
    check_eq("pre_rst_count", count_o, 32'h02020202);
    reset_n_i = 1'b0;
    #2;
    check_eq("mid_rst_count", count_o, 32'h0);
    check_eq("mid_rst_pending", 32'(pending_o), 32'h0);
    check_eq("mid_rst_irq", 32'(irq_o), 32'h0);
    tick(1);
    reset_n_i = 1'b1;
    ev(4'b0001);
    check_eq("post_rst_disabled", cnt(0), 32'd0);
    cfg_write(0, 1'b1, 8'd5, 16'd0);
    ev(4'b0001);
    check_eq("post_rst_count", cnt(0), 32'd1);
    check_eq("post_rst_pending", 32'(pending_o), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
